serial_add_ctrl: RTL and testbench

// - Bit-serial W-bit adder controller: accepts two operands and a carry-in over a valid/ready

---
 rtl/serial_add_pkg.sv | 25 ++
 rtl/fa_bit.sv | 30 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared state encoding and parameter check for the bit-serial adder controller.
// The width-check macro is expanded inside the top module's body.
`define SERIAL_ADD_CHECK_W(w) \
  if (((w) < 2) || ((w) > 32)) begin : g_bad_w \
    $error("serial_add_ctrl: W must be in 2..32"); \
  end

package serial_add_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  function automatic logic ovf_flag(input logic c_in_msb, input logic c_out_msb);
    return c_in_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational one-bit full adder: two half adders chained, carries ORed.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder, the basic cell the serial full adder is built from.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: operands accepted over valid/ready, summed LSB-first
// through a single full-add cell, result held in DONE until the consumer takes it.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  `SERIAL_ADD_CHECK_W(W)

  state_e           state_q, state_d;
  logic [W-1:0]     a_sr_q, a_sr_d;
  logic [W-1:0]     b_sr_q, b_sr_d;
  logic [W-1:0]     sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;

  logic fa_s;
  logic fa_co;

  fa_bit u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    sum_sr_d   = sum_sr_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sr_d   = in_a;
          b_sr_d   = in_b;
          sum_sr_d = '0;
          carry_d  = in_cin;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[W-1:1]};
        b_sr_d   = {1'b0, b_sr_q[W-1:1]};
        sum_sr_d = {fa_s, sum_sr_q[W-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Last bit: carry_q is still the carry into the MSB here.
          out_sum_d  = {fa_s, sum_sr_q[W-1:1]};
          out_cout_d = fa_co;
          out_ovf_d  = ovf_flag(carry_q, fa_co);
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything; a result in flight never reaches the outputs.
    if (clr) begin
      state_d    = ST_IDLE;
      a_sr_d     = a_sr_q;
      b_sr_d     = b_sr_q;
      sum_sr_d   = sum_sr_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      out_sum_d  = out_sum_q;
      out_cout_d = out_cout_q;
      out_ovf_d  = out_ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      sum_sr_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      sum_sr_q   <= sum_sr_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (W=8) with an expected-result queue.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int   total;
  int   bad;
  res_t sb[$];

  serial_add_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] full;
    res_t r;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  // Present operands for one acceptance edge and record the expected result.
  task automatic op_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    sb.push_back(model(a, b, cin));
    chk("accept_in_ready_low", {31'd0, in_ready}, 32'd0);
  endtask

  // Wait for out_valid, check latency from acceptance and compare with the queue.
  task automatic wait_done(input string tag);
    int   n;
    res_t e;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, W);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"},  {24'd0, out_sum},  {24'd0, e.sum});
      chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, e.cout});
      chk({tag, "_ovf"},  {31'd0, out_ovf},  {31'd0, e.ovf});
    end else begin
      chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int   seen_valid;
    res_t held;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;

    step();
    step();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_sum",       {24'd0, out_sum},   32'd0);
    chk("rst_cout",      {31'd0, out_cout},  32'd0);
    chk("rst_ovf",       {31'd0, out_ovf},   32'd0);
    rst_n = 1'b1;
    step();

    op_start(8'h0F, 8'h01, 1'b0);
    wait_done("op_0f_01");
    release_out("op_0f_01");

    op_start(8'hFF, 8'h01, 1'b0);
    wait_done("op_ff_01");
    release_out("op_ff_01");

    op_start(8'h7F, 8'h00, 1'b1);
    wait_done("op_7f_00_c");
    release_out("op_7f_00_c");

    // Reset in the middle of a run: outputs return to reset values without an edge.
    op_start(8'h12, 8'h34, 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_busy",      {31'd0, busy},      32'd0);
    chk("midrst_sum",       {24'd0, out_sum},   32'd0);
    chk("midrst_cout",      {31'd0, out_cout},  32'd0);
    void'(sb.pop_back());
    step();
    rst_n = 1'b1;
    step();

    op_start(8'h55, 8'hAA, 1'b0);
    wait_done("op_55_aa");
    release_out("op_55_aa");

    // Abort in RUN cycle 3; the previous result must remain on the outputs.
    op_start(8'h20, 8'h30, 1'b0);
    repeat (3) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_busy",     {31'd0, busy},     32'd0);
    void'(sb.pop_back());
    seen_valid = 0;
    repeat (W + 2) begin
      step();
      if (out_valid) seen_valid++;
    end
    chk("clr_no_valid",   seen_valid,         32'd0);
    chk("clr_sum_retain", {24'd0, out_sum},   32'h0000_00FF);

    // clr together with in_valid in IDLE must not accept.
    in_a     = 8'h77;
    in_b     = 8'h11;
    in_valid = 1'b1;
    clr      = 1'b1;
    step();
    in_valid = 1'b0;
    clr      = 1'b0;
    chk("clr_idle_noaccept", {31'd0, busy}, 32'd0);

    op_start(8'h01, 8'h01, 1'b1);
    wait_done("op_01_01_c");
    release_out("op_01_01_c");

    // Backpressure: DONE holds while a new request is offered.
    op_start(8'h80, 8'h80, 1'b0);
    wait_done("op_80_80");
    held.sum  = out_sum;
    held.cout = out_cout;
    held.ovf  = out_ovf;
    in_a      = 8'h33;
    in_b      = 8'h44;
    in_cin    = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_valid",    {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready},  32'd0);
      chk("bp_stable",   {22'd0, out_sum, out_cout, out_ovf}, {22'd0, held.sum, held.cout, held.ovf});
    end
    in_valid = 1'b0;
    release_out("bp");
    chk("bp_queue_empty", sb.size(), 32'd0);
    step();
    chk("bp_not_accepted", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
